// File: rtl/rbot_pkg.sv
// Shared types for the cube-robot move executor.
// Face indices, turn-type codes, executor states and the latched move record.
package rbot_pkg;

  typedef enum logic [2:0] {
    FACE_RIGHT = 3'd0,
    FACE_UP    = 3'd1,
    FACE_FRONT = 3'd2,
    FACE_LEFT  = 3'd3,
    FACE_BACK  = 3'd4,
    FACE_DOWN  = 3'd5
  } face_e;

  typedef enum logic [1:0] {
    TURN_CW   = 2'b00,
    TURN_CCW  = 2'b01,
    TURN_HALF = 2'b10,
    TURN_BAD  = 2'b11
  } turn_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_DONE
  } state_e;

  // Matches the move_code layout: [4:3] turn, [2:0] face.
  typedef struct packed {
    turn_e      turn;
    logic [2:0] face;
  } move_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable count-down timer; expire_o is high in the last cycle of a
// loaded interval. Ports: clock, reset_n, load_i/val_i, clr_i, expire_o.
module step_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // A value of N loaded on an edge expires N cycles later.
  assign expire_o = (cnt_q == W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/move_executor.sv
// Runs one face turn on a stepper driver: enable/dir setup, step train, settle.
// Ports: move_code/move_valid/move_ready in, abort, dir/step/en pins, done/err/busy.
module move_executor
  import rbot_pkg::*;
#(
  parameter int NUM_AXES      = 6,
  parameter int QUARTER_STEPS = 50,
  parameter int STEP_HALF     = 500000,
  parameter int DIR_SETUP     = 1000,
  parameter int SETTLE        = 2000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [4:0]          move_code,
  input  logic                move_valid,
  output logic                move_ready,
  input  logic                abort,
  output logic                dir_pin,
  output logic                step_pin,
  output logic [NUM_AXES-1:0] en_pins,
  output logic                move_done,
  output logic                move_err,
  output logic                busy
);

  localparam int TMAX = max3(DIR_SETUP, STEP_HALF, SETTLE);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SMAX = 2 * QUARTER_STEPS;
  localparam int SW   = $clog2(SMAX + 1);

  state_e        state_q, state_d;
  move_t         mv_q, mv_d, mv_in;
  logic [SW-1:0] cnt_q, cnt_d, tgt;

  logic          tm_load, tm_exp;
  logic [TW-1:0] tm_val;

  logic          legal, cancel, active;
  logic          err_d;

  logic [NUM_AXES-1:0] en_d, en_q;
  logic                dir_d, dir_q;
  logic                step_d, step_q;
  logic                done_d, done_q;
  logic                err_q, busy_q, ready_q;

  assign mv_in  = move_t'(move_code);
  assign legal  = (int'(mv_in.face) < NUM_AXES)
               && (mv_in.turn != TURN_BAD);
  assign cancel = abort && (state_q != ST_IDLE);
  assign tgt    = (mv_q.turn == TURN_HALF)
               ? SW'(SMAX) : SW'(QUARTER_STEPS);

  step_timer #(
    .W(TW)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (tm_load),
    .clr_i    (cancel),
    .val_i    (tm_val),
    .expire_o (tm_exp)
  );

  always_comb begin
    state_d = state_q;
    mv_d    = mv_q;
    cnt_d   = cnt_q;
    tm_load = 1'b0;
    tm_val  = '0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (move_valid) begin
          if (legal) begin
            mv_d    = mv_in;
            cnt_d   = '0;
            state_d = ST_SETUP;
            tm_load = 1'b1;
            tm_val  = TW'(DIR_SETUP);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tm_exp) begin
          state_d = ST_STEP_HI;
          tm_load = 1'b1;
          tm_val  = TW'(STEP_HALF);
        end
      end
      ST_STEP_HI: begin
        if (tm_exp) begin
          state_d = ST_STEP_LO;
          tm_load = 1'b1;
          tm_val  = TW'(STEP_HALF);
        end
      end
      ST_STEP_LO: begin
        if (tm_exp) begin
          cnt_d   = cnt_q + SW'(1);
          tm_load = 1'b1;
          if (cnt_d >= tgt) begin
            state_d = ST_SETTLE;
            tm_val  = TW'(SETTLE);
          end else begin
            state_d = ST_STEP_HI;
            tm_val  = TW'(STEP_HALF);
          end
        end
      end
      ST_SETTLE: begin
        if (tm_exp) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (cancel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tm_load = 1'b1;
      tm_val  = '0;
    end
  end

  // Pin outputs follow the current state one edge later, so every pin
  // moves on the edge after its state is entered; a cancel zeroes them
  // on the same edge that returns the state to idle.
  always_comb begin
    active = !cancel
          && (state_q inside {ST_SETUP, ST_STEP_HI,
                              ST_STEP_LO, ST_SETTLE});
    for (int i = 0; i < NUM_AXES; i++) begin
      en_d[i] = active && (int'(mv_q.face) == i);
    end
    dir_d  = active && (mv_q.turn != TURN_CCW);
    step_d = !cancel && (state_q == ST_STEP_HI);
    done_d = !cancel && (state_q == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mv_q    <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mv_q    <= mv_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign move_ready = ready_q;
  assign busy       = busy_q;
  assign en_pins    = en_q;
  assign dir_pin    = dir_q;
  assign step_pin   = step_q;
  assign move_done  = done_q;
  assign move_err   = err_q;

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor: random and directed moves, aborts,
// reset mid-move; a monitor matches each observed outcome to its prediction.
module tb_move_executor;

  localparam int NA = 6;
  localparam int QS = 4;
  localparam int SH = 2;
  localparam int DS = 3;
  localparam int ST = 5;

  localparam int K_DONE   = 0;
  localparam int K_ERR    = 1;
  localparam int K_CANCEL = 2;

  typedef struct {
    int         kind;
    int         edge_n;
    logic [5:0] en;
    logic       dir;
    int         pulses;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    move_code = '0;
  logic          move_valid = 1'b0;
  logic          abort = 1'b0;
  logic          move_ready;
  logic          dir_pin;
  logic          step_pin;
  logic [NA-1:0] en_pins;
  logic          move_done;
  logic          move_err;
  logic          busy;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   next_acc = -1;
  exp_t sbq[$];

  move_executor #(
    .NUM_AXES      (NA),
    .QUARTER_STEPS (QS),
    .STEP_HALF     (SH),
    .DIR_SETUP     (DS),
    .SETTLE        (ST)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .move_code  (move_code),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .abort      (abort),
    .dir_pin    (dir_pin),
    .step_pin   (step_pin),
    .en_pins    (en_pins),
    .move_done  (move_done),
    .move_err   (move_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model of a move, straight from the turn rules.
  function automatic bit m_legal(input logic [4:0] c);
    return (int'(c[2:0]) < NA) && (c[4:3] != 2'b11);
  endfunction

  function automatic int m_target(input logic [4:0] c);
    return (c[4:3] == 2'b10) ? 2 * QS : QS;
  endfunction

  function automatic int m_latency(input logic [4:0] c);
    return DS + 2 * SH * m_target(c) + ST + 1;
  endfunction

  function automatic logic [5:0] m_en(input logic [4:0] c);
    logic [5:0] v;
    v = 6'd1 << c[2:0];
    return v;
  endfunction

  function automatic logic m_dir(input logic [4:0] c);
    return c[4:3] != 2'b01;
  endfunction

  // Offer a move with valid held until accepted; optionally abort it
  // during its second step-high phase.
  task automatic issue(input logic [4:0] code, input bit cancel_it,
                       input bit abort_at_acc, output int acc);
    int   w;
    int   rises;
    logic prev;
    exp_t e;
    move_valid = 1'b1;
    move_code  = code;
    w = 0;
    while (!move_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (!move_ready) begin
      chk("ready_timeout", int'(move_ready), 1);
      move_valid = 1'b0;
      next_acc = -1;
      acc = -1;
      return;
    end
    abort = abort_at_acc;
    acc = cyc + 1;
    if (next_acc >= 0) chk("accept_edge", acc, next_acc);
    next_acc = -1;
    if (!m_legal(code)) begin
      e = '{K_ERR, acc, 6'd0, 1'b0, 0};
      sbq.push_back(e);
      next_acc = acc + 1;
    end else if (!cancel_it) begin
      e = '{K_DONE, acc + m_latency(code), m_en(code),
            m_dir(code), m_target(code)};
      sbq.push_back(e);
      next_acc = e.edge_n + 1;
    end
    @(negedge clock);
    abort = 1'b0;
    move_valid = 1'b0;
    move_code = 5'($urandom);
    if (m_legal(code) && cancel_it) begin
      rises = 0;
      prev = step_pin;
      w = 0;
      while (rises < 2 && w < 200) begin
        @(negedge clock);
        w++;
        if (step_pin && !prev) rises++;
        prev = step_pin;
      end
      if (rises < 2) begin
        chk("abort_wait", rises, 2);
      end else begin
        abort = 1'b1;
        e = '{K_CANCEL, cyc + 1, m_en(code), m_dir(code), 2};
        sbq.push_back(e);
        next_acc = cyc + 2;
        @(negedge clock);
        abort = 1'b0;
      end
    end
  endtask

  // Monitor: one outcome per move, matched in order against predictions.
  logic       prev_step = 1'b0;
  bit         in_move = 1'b0;
  logic [5:0] s_en;
  logic       s_dir;
  int         pulses;
  bit         rdy_bad;
  bit         hold_bad;
  exp_t       me;

  always @(negedge clock) begin
    if (move_err) begin
      chk("err_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        chk("err_kind", K_ERR, me.kind);
        chk("err_edge", cyc, me.edge_n);
        chk("err_quiet", int'({en_pins, step_pin}), 0);
      end
    end
    if (in_move && en_pins == '0) begin
      in_move = 1'b0;
      chk("end_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        chk("end_kind", move_done ? K_DONE : K_CANCEL, me.kind);
        chk("end_edge", cyc, me.edge_n);
        chk("en_pattern", int'(s_en), int'(me.en));
        chk("dir", int'(s_dir), int'(me.dir));
        chk("pulses", pulses, me.pulses);
        chk("ready_low", int'(rdy_bad), 0);
        chk("pins_steady", int'(hold_bad), 0);
        chk("step_idle", int'(step_pin), 0);
      end
    end else if (in_move) begin
      if (step_pin && !prev_step) pulses++;
      if (move_ready) rdy_bad = 1'b1;
      if (en_pins != s_en || dir_pin != s_dir || move_done)
        hold_bad = 1'b1;
    end else if (en_pins != '0) begin
      in_move  = 1'b1;
      s_en     = en_pins;
      s_dir    = dir_pin;
      pulses   = 0;
      rdy_bad  = move_ready;
      hold_bad = step_pin || move_done;
    end else begin
      chk("idle_quiet", int'({move_done, step_pin}), 0);
    end
    prev_step = step_pin;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int w;
    exp_t e;
    bit   cx;
    bit   ab;
    logic [4:0] c;

    #2;
    chk("rst_pins", int'({en_pins, step_pin, dir_pin}), 0);
    chk("rst_flags", int'({move_done, move_err, busy}), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", int'(move_ready), 1);
    chk("rst_busy", int'(busy), 0);

    issue(5'b00_000, 1'b0, 1'b0, acc);
    issue(5'b10_011, 1'b0, 1'b0, acc);
    issue(5'b11_001, 1'b0, 1'b0, acc);
    issue(5'b00_110, 1'b0, 1'b0, acc);
    issue(5'b01_010, 1'b1, 1'b0, acc);

    // Reset during the settle phase of a CW move on face 0.
    issue(5'b00_000, 1'b0, 1'b0, acc);
    w = 0;
    while (cyc < acc + DS + 2 * SH * QS + 2 && w < 100) begin
      @(negedge clock);
      w++;
    end
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_pins", int'({en_pins, step_pin, dir_pin}), 0);
    chk("mid_rst_flags", int'({move_done, move_err, busy}), 0);
    e = sbq.pop_back();
    e.kind = K_CANCEL;
    e.edge_n = cyc + 1;
    sbq.push_back(e);
    next_acc = -1;
    @(negedge clock);
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", int'(move_ready), 1);
    issue(5'b01_101, 1'b0, 1'b0, acc);

    for (int i = 0; i < 40; i++) begin
      c  = 5'($urandom_range(0, 31));
      cx = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 3) == 0);
      issue(c, cx, ab, acc);
    end

    move_valid = 1'b0;
    w = 0;
    while ((sbq.size() != 0 || busy) && w < 400) begin
      @(negedge clock);
      w++;
    end
    chk("drain", sbq.size(), 0);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 SHALL have parameter NUM_AXES, default 6, number of stepper channels (face order RIGHT=0, UP=1, FRONT=2, LEFT=3, BACK=4, DOWN=5).
REQ-002 SHALL have parameter QUARTER_STEPS, default 50, step pulses per quarter turn.
REQ-003 SHALL have parameter STEP_HALF, default 500000, clock cycles per step_pin high phase and per low phase.
REQ-004 SHALL have parameter DIR_SETUP, default 1000, cycles between enable/dir assertion and first step edge.
REQ-005 SHALL have parameter SETTLE, default 2000000, cycles of enable hold after the last step.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 move_code  input  5  [2:0] face index, [4:3] turn type: 00 CW quarter, 01 CCW quarter, 10 half, 11 illegal.
REQ-009 move_valid  input  1  move_code is offered.
REQ-010 move_ready  output  1  block accepts a move this cycle.
REQ-011 abort  input  1  synchronous cancel of the current move.
REQ-012 dir_pin  output  1  rotation direction, 1 = CW.
REQ-013 step_pin  output  1  step pulse train to all drivers.
REQ-014 en_pins  output  NUM_AXES  one-hot enable of the selected driver, active-high.
REQ-015 move_done  output  1  one-cycle pulse, move completed.
REQ-016 move_err  output  1  one-cycle pulse, move rejected.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL accept a move on a rising edge where move_valid and move_ready are both high; move_ready SHALL equal (state == IDLE).
REQ-019 SHALL register move_code at acceptance; later move_code changes SHALL have no effect until the next acceptance.
REQ-020 SHALL implement states IDLE, SETUP, STEP_HI, STEP_LO, SETTLE, DONE.
REQ-021 IDLE->SETUP on a legal accept; legal means face < NUM_AXES and turn type != 11.
REQ-022 On an illegal accept SHALL stay in IDLE, pulse move_err next cycle, drive no outputs otherwise.
REQ-023 SETUP SHALL drive en_pins[face]=1 and dir_pin (1 for 00 and 10, 0 for 01) for DIR_SETUP cycles, step_pin=0, then go to STEP_HI.
REQ-024 STEP_HI drives step_pin=1 for STEP_HALF cycles; STEP_LO drives step_pin=0 for STEP_HALF cycles, then increments step count.
REQ-025 Step target SHALL be QUARTER_STEPS for types 00/01 and 2*QUARTER_STEPS for type 10; STEP_LO->STEP_HI while count < target, else ->SETTLE.
REQ-026 SETTLE SHALL hold en_pins and dir_pin with step_pin=0 for SETTLE cycles, then ->DONE.
REQ-027 DONE SHALL last one cycle with move_done=1 and en_pins=0, then ->IDLE.
REQ-028 move_done SHALL rise exactly DIR_SETUP + 2*STEP_HALF*target + SETTLE + 1 cycles after the accepting edge.
REQ-029 abort high in any non-IDLE state SHALL force IDLE at the next edge with step_pin=0, en_pins=0, no move_done; abort in IDLE SHALL be ignored.
REQ-030 abort and move_valid together in IDLE SHALL accept the move normally.
REQ-031 Counters SHALL be sized $clog2 of their maximum value plus one; no counter SHALL wrap.
REQ-032 All outputs SHALL be registered; en_pins SHALL never have more than one bit set.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, counters 0, step_pin=0, dir_pin=0, en_pins=0, move_done=0, move_err=0, busy=0; move_ready=1 after release.
REQ-034 Reset mid-move SHALL abandon the move without move_done.

Structure
REQ-035 Face indices, turn-type codes and the state enum SHALL live in shared package rbot_pkg.
REQ-036 The step-phase timer SHALL be sub-module step_timer (load, count-down, expire pulse), reused for SETUP, step phases and SETTLE.

Verification (QUARTER_STEPS=4, STEP_HALF=2, DIR_SETUP=3, SETTLE=5)
REQ-037 Accept code 5'b00_000 -> en_pins=000001, dir_pin=1, 4 step_pin pulses 2 high/2 low, move_done 25 cycles after accept.
REQ-038 Accept code 5'b10_011 -> en_pins=001000, 8 pulses, move_done 41 cycles after accept.
REQ-039 Codes 5'b11_001 and 5'b00_110 -> move_err pulse, no en/step activity, move_ready stays 1.
REQ-040 abort during 2nd STEP_HI of 5'b01_010 -> IDLE next edge, outputs zero, no move_done.
REQ-041 reset_n low during SETTLE -> all outputs zero asynchronously; after release a new move completes normally.
REQ-042 Back-to-back moves with move_valid held high -> second accepted the cycle after move_done, move_ready low throughout each move.
